// File: rtl/rv_mem_seq.sv
`default_nettype none
// ============================================================================
// Module   : rv_mem_seq
// Brief    : Memory access sequencer. Takes one core access at a time over a
//            valid/ready channel, runs a req/ack handshake to a variable-latency
//            single-port memory, and returns a one-cycle response pulse.
// Revision : 1.0 - initial release
// ============================================================================
module rv_mem_seq #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Wait counter only needs to reach TIMEOUT; keep at least one bit when disabled.
  localparam int               CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and register-update decode; every flop holds unless changed below.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          if (req_addr[1:0] != 2'b00) begin
            // Misaligned word access: answer with an error, never touch memory.
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc;
          // An ack in the TIMEOUT-th cycle wins; only a missing ack expires.
          if ((TIMEOUT != 0) && (cnt_inc == TO_VAL)) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Control outputs decode from state alone, so reset drops mem_req at once.
  assign req_ready = (state_q == S_IDLE);
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = we_q & mem_req;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = err_q & rsp_valid;
  assign rsp_rdata = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_mem_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_mem_seq
// Brief    : Scoreboard bench for rv_mem_seq with a small programmable memory
//            responder (TIMEOUT = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_mem_seq;

  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  rv_mem_seq #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          t;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  // Memory responder controls
  bit          ack_always = 0;
  int          ack_on     = 0;
  bit          addr_data  = 0;
  logic [31:0] rdata_val  = '0;
  int          rcyc       = 0;
  int          mreq_cycles = 0;
  logic        cur_we     = 0;
  logic [31:0] cur_addr   = '0;
  logic [31:0] cur_wdata  = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: acks on a chosen REQ cycle and checks request stability.
  initial begin
    mem_ack   = 0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        rcyc++;
        mreq_cycles++;
        chk("mem_addr", mem_addr, cur_addr);
        chk("mem_wdata", mem_wdata, cur_wdata);
        chk("mem_we", mem_we, cur_we);
      end else begin
        rcyc = 0;
      end
      mem_ack   = ack_always || (mem_req && ack_on != 0 && rcyc == ack_on);
      mem_rdata = addr_data ? (mem_addr ^ 32'hA5A5_0000) : rdata_val;
    end
  end

  // Monitor: pops the scoreboard on each response pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", rsp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_time", cyc, e.t);
        end
      end else begin
        chk("rsp_err_idle", rsp_err, 0);
      end
    end
  end

  // Present one request and wait until it is accepted; acc = cycle after accept edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rdata, input int lat,
                       input bit keep, output int acc);
    exp_t e;
    int   n;
    req_valid = 1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept", req_ready, 1);
    cur_we    = we;
    cur_addr  = addr;
    cur_wdata = wdata;
    e.err   = exp_err;
    e.rdata = exp_rdata;
    e.t     = cyc + 1 + lat;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    if (!keep) req_valid = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_pending", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2;
    rst = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    #1 rst = 0;
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    repeat (3) @(negedge clk);
    rst = 1;

    // Zero-wait read with mem_ack tied high
    ack_always = 1; rdata_val = 32'hDEAD_BEEF; mreq_cycles = 0;
    issue(0, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, 1, 0, a1);
    wait_done();
    chk("t1_mreq_cycles", mreq_cycles, 1);

    // Store with 3 wait states; store ack must not update rsp_rdata
    ack_always = 0; ack_on = 4; rdata_val = 32'hAAAA_5555; mreq_cycles = 0;
    issue(1, 32'h24, 32'h1234_5678, 0, 32'hDEAD_BEEF, 4, 0, a1);
    wait_done();
    chk("t2_mreq_cycles", mreq_cycles, 4);

    // Misaligned: no memory access, error one cycle after accept; stray acks ignored
    ack_always = 1; mreq_cycles = 0;
    issue(0, 32'h102, 32'h0, 1, 32'hDEAD_BEEF, 0, 0, a1);
    wait_done();
    chk("t3_mreq_cycles", mreq_cycles, 0);

    // Timeout: never acked
    ack_always = 0; ack_on = 0; mreq_cycles = 0;
    issue(0, 32'h40, 32'h0, 1, 32'hDEAD_BEEF, TO, 0, a1);
    wait_done();
    chk("t4_mreq_cycles", mreq_cycles, TO);

    // Ack in the last allowed REQ cycle succeeds
    ack_on = TO; rdata_val = 32'hCAFE_F00D; mreq_cycles = 0;
    issue(0, 32'h80, 32'h0, 0, 32'hCAFE_F00D, TO, 0, a1);
    wait_done();
    chk("t5_mreq_cycles", mreq_cycles, TO);

    // Reset in the second REQ cycle
    ack_on = 0;
    issue(0, 32'h200, 32'h0, 0, 32'h0, 99, 0, a1);
    @(negedge clk);
    #2 rst = 0;
    #1;
    chk("t6_mem_req_async", mem_req, 0);
    chk("t6_ready_async", req_ready, 1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    chk("t6_ready", req_ready, 1);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_rdata", rsp_rdata, 0);
    chk("t6_mem_addr", mem_addr, 0);
    @(negedge clk);

    // Back-to-back with req_valid held high
    ack_always = 1; addr_data = 1; mreq_cycles = 0;
    issue(0, 32'h0, 32'h0, 0, 32'hA5A5_0000, 1, 1, a1);
    issue(0, 32'h4, 32'h0, 0, 32'hA5A5_0004, 1, 0, a2);
    wait_done();
    chk("t7_accept_gap", a2 - a1, 3);
    chk("t7_mreq_cycles", mreq_cycles, 2);

    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
